// File: rtl/ble_rx_packet_ctrl.sv
// ble_rx_packet_ctrl: sequences the BLE receive datapath (reset, mode select)
// and frames the recovered bit stream into header/payload/CRC bytes.
// Optional feature macro: BLE_DEWHITEN_EN (dewhiten HEADER/PAYLOAD bits with
// the channel-seeded x^7+x^4+1 LFSR). Undefined: bits pass raw.
module ble_rx_packet_ctrl #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int unsigned MAX_AA_ERR  = 1,
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] cfg_select,
  input  logic [5:0] chan_idx,
  input  logic       update,
  input  logic       value,
  output logic [1:0] dp_select,
  output logic       dp_rst,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DPRST   = 3'd1;
  localparam logic [2:0] S_SEARCH  = 3'd2;
  localparam logic [2:0] S_HEADER  = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;

  localparam int unsigned RW = $clog2(RST_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic          upd_q;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   win_q, win_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sh_q, sh_d;
  logic [1:0]    dp_select_q, dp_select_d;
  logic          dp_rst_q, dp_rst_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          byte_last_q, byte_last_d;
  logic          pkt_done_q, pkt_done_d;
  logic          pkt_err_q, pkt_err_d;

  logic        bit_stb;
  logic        rx_bit;
  logic [31:0] win_next;
  logic [31:0] aa_diff;
  logic [5:0]  aa_err;
  logic        aa_hit;
  logic [7:0]  byte_next;
  logic        abort;

  assign bit_stb = update & ~upd_q;

`ifdef BLE_DEWHITEN_EN
  logic [6:0] lfsr_q, lfsr_d;
  assign rx_bit = value ^ lfsr_q[6];
`else
  logic unused_chan;
  assign unused_chan = ^chan_idx;
  assign rx_bit = value;
`endif

  // Sliding access-address window and its Hamming distance to ACCESS_ADDR
  always_comb begin
    win_next = {value, win_q[31:1]};
    aa_diff  = win_next ^ ACCESS_ADDR;
    aa_err   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      aa_err = aa_err + 6'(aa_diff[i]);
    end
    aa_hit    = (32'(aa_err) <= MAX_AA_ERR);
    byte_next = {rx_bit, sh_q[7:1]};
  end

  // Packet FSM, byte buffer handshake, timeout and datapath control
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    tmo_d        = tmo_q;
    win_d        = win_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    sh_d         = sh_q;
    dp_select_d  = dp_select_q;
    dp_rst_d     = dp_rst_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    pkt_done_d   = 1'b0;
    pkt_err_d    = 1'b0;
    abort        = 1'b0;
`ifdef BLE_DEWHITEN_EN
    lfsr_d       = lfsr_q;
`endif

    if (byte_valid_q && byte_ready) begin
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        dp_rst_d = 1'b1;
        if (enable) begin
          dp_select_d = cfg_select;
          rst_cnt_d   = '0;
          state_d     = S_DPRST;
        end
      end
      S_DPRST: begin
        dp_rst_d  = 1'b1;
        rst_cnt_d = rst_cnt_q + RW'(1);
        if (rst_cnt_q == RST_LAST) begin
          dp_rst_d = 1'b0;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (bit_stb) begin
          win_d = win_next;
          if (aa_hit) begin
            win_d      = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            tmo_d      = '0;
            state_d    = S_HEADER;
`ifdef BLE_DEWHITEN_EN
            lfsr_d     = {chan_idx, 1'b1};
`endif
          end
        end
      end
      S_HEADER, S_PAYLOAD: begin
        if (bit_stb) begin
          tmo_d     = '0;
          sh_d      = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef BLE_DEWHITEN_EN
          lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
`endif
          if (bit_cnt_q == 3'd7) begin
            // A held byte not accepted this cycle would be overwritten
            if (byte_valid_q && !byte_ready) begin
              abort = 1'b1;
            end else begin
              byte_data_d  = byte_next;
              byte_valid_d = 1'b1;
              byte_cnt_d   = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 9'd1;
              if (state_q == S_HEADER && byte_cnt_q == 9'd1) begin
                len_d      = byte_next;
                byte_cnt_d = '0;
                state_d    = S_PAYLOAD;
              end else if (state_q == S_PAYLOAD &&
                           byte_cnt_q == {1'b0, len_q} + 9'd2) begin
                byte_last_d = 1'b1;
                state_d     = S_DONE;
              end
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        if (!byte_valid_q || byte_ready) begin
          pkt_done_d = 1'b1;
          state_d    = S_SEARCH;
        end
      end
      S_ABORT: begin
        dp_rst_d    = 1'b1;
        dp_select_d = cfg_select;
        rst_cnt_d   = '0;
        state_d     = S_DPRST;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_ABORT;
      pkt_err_d    = 1'b1;
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
      win_d        = '0;
      dp_rst_d     = 1'b1;
    end

    // enable low overrides everything: quiet return to IDLE without pkt_err
    if (!enable) begin
      state_d      = S_IDLE;
      dp_rst_d     = 1'b1;
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
      pkt_done_d   = 1'b0;
      pkt_err_d    = 1'b0;
      win_d        = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      upd_q        <= 1'b0;
      rst_cnt_q    <= '0;
      tmo_q        <= '0;
      win_q        <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      sh_q         <= '0;
      dp_select_q  <= '0;
      dp_rst_q     <= 1'b1;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      upd_q        <= update;
      rst_cnt_q    <= rst_cnt_d;
      tmo_q        <= tmo_d;
      win_q        <= win_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      len_q        <= len_d;
      sh_q         <= sh_d;
      dp_select_q  <= dp_select_d;
      dp_rst_q     <= dp_rst_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      pkt_done_q   <= pkt_done_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

`ifdef BLE_DEWHITEN_EN
  // Dewhitening LFSR register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= '0;
    else      lfsr_q <= lfsr_d;
  end
`endif

  assign dp_select  = dp_select_q;
  assign dp_rst     = dp_rst_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_err    = pkt_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ble_rx_packet_ctrl.sv
// Testbench for ble_rx_packet_ctrl: directed vectors, table-driven AA matching
// and packet framing, plus hand-written timeout/overflow sequences.
module tb_ble_rx_packet_ctrl;

  localparam logic [31:0] AA = 32'h8E89BED6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] cfg_select;
  logic [5:0] chan_idx;
  logic       update;
  logic       value;
  logic [1:0] dp_select;
  logic       dp_rst;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic       pkt_done;
  logic       pkt_err;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [8:0] rxq[$];
  logic [6:0] wl;

  typedef struct {
    string       name;
    logic [31:0] aa;
    logic [2:0]  exp_state;
  } aa_vec_t;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } pb_t;

  ble_rx_packet_ctrl #(
    .ACCESS_ADDR (32'h8E89BED6),
    .MAX_AA_ERR  (1),
    .RST_CYC     (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .enable     (enable),
    .cfg_select (cfg_select),
    .chan_idx   (chan_idx),
    .update     (update),
    .value      (value),
    .dp_select  (dp_select),
    .dp_rst     (dp_rst),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid && byte_ready) rxq.push_back({byte_last, byte_data});
    if (pkt_done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    value  = b;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_aa(input logic [31:0] a);
    for (int i = 0; i < 32; i++) send_bit(a[i]);
    wl = {chan_idx, 1'b1};
  endtask

  // Whitening is its own inverse; the raw build sends bytes unmodified
  task automatic send_data_byte(input logic [7:0] b);
    logic wb;
    for (int i = 0; i < 8; i++) begin
      wb = b[i];
`ifdef BLE_DEWHITEN_EN
      wb = wb ^ wl[6];
      wl = {wl[5:0], wl[6] ^ wl[3]};
`endif
      send_bit(wb);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    for (int k = 0; k < lim; k++) begin
      if (state_dbg == s) break;
      @(negedge clk);
    end
    chk(nm, 32'(state_dbg), 32'(s));
  endtask

  task automatic resync();
    enable = 1'b0;
    @(negedge clk);
    chk("enable_low_state", 32'(state_dbg), 32'd0);
    chk("enable_low_dprst", 32'(dp_rst), 32'd1);
    enable = 1'b1;
    wait_state(3'd2, 60, "resync_search");
  endtask

  aa_vec_t aa_tab[6];
  pb_t     pkt2[8];
  pb_t     pkt6[7];

  initial begin
    int dcnt;
    int k;
    logic [8:0] e;

    aa_tab[0] = '{"aa_exact",     AA,                    3'd3};
    aa_tab[1] = '{"aa_flip_b0",   AA ^ 32'h0000_0001,    3'd3};
    aa_tab[2] = '{"aa_flip_b31",  AA ^ 32'h8000_0000,    3'd3};
    aa_tab[3] = '{"aa_flip_2lo",  AA ^ 32'h0000_0003,    3'd2};
    aa_tab[4] = '{"aa_flip_2far", AA ^ 32'h8001_0000,    3'd2};
    aa_tab[5] = '{"aa_inverted",  ~AA,                   3'd2};

    pkt2[0] = '{8'h02, 1'b0}; pkt2[1] = '{8'h03, 1'b0};
    pkt2[2] = '{8'hAA, 1'b0}; pkt2[3] = '{8'hBB, 1'b0};
    pkt2[4] = '{8'hCC, 1'b0}; pkt2[5] = '{8'h11, 1'b0};
    pkt2[6] = '{8'h22, 1'b0}; pkt2[7] = '{8'h33, 1'b1};

    pkt6[0] = '{8'h40, 1'b0}; pkt6[1] = '{8'h02, 1'b0};
    pkt6[2] = '{8'hDE, 1'b0}; pkt6[3] = '{8'hAD, 1'b0};
    pkt6[4] = '{8'hC1, 1'b0}; pkt6[5] = '{8'hC2, 1'b0};
    pkt6[6] = '{8'hC3, 1'b1};

    rst_n = 1'b0; enable = 1'b1; cfg_select = 2'd1; chan_idx = 6'd37;
    update = 1'b0; value = 1'b0; byte_ready = 1'b1; wl = '0;

    // 1. reset values, then 16 cycles of datapath reset before SEARCH
    repeat (5) @(negedge clk);
    chk("rst_dp_select", 32'(dp_select), 32'd0);
    chk("rst_dp_rst", 32'(dp_rst), 32'd1);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_last", 32'(byte_last), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_err", 32'(pkt_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (state_dbg == 3'd1 && dp_rst) dcnt++;
      if (state_dbg == 3'd2) break;
    end
    chk("dprst_cycles", 32'(dcnt), 32'd16);
    chk("search_state", 32'(state_dbg), 32'd2);
    chk("search_dp_rst", 32'(dp_rst), 32'd0);
    chk("search_dp_select", 32'(dp_select), 32'd1);
    chk("search_outputs", 32'({byte_valid, byte_last, pkt_done, pkt_err, byte_data}), 32'd0);

    // 2. clean packet; cfg_select changes mid-packet and must be ignored
    send_aa(AA);
    chk("lock_state", 32'(state_dbg), 32'd3);
    for (int i = 0; i < 8; i++) begin
      send_data_byte(pkt2[i].b);
      if (i == 1) cfg_select = 2'd2;
    end
    repeat (4) @(negedge clk);
    chk("pkt2_count", 32'(rxq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      e = (rxq.size() > 0) ? rxq.pop_front() : 9'h1FF;
      chk($sformatf("pkt2_byte%0d", i), 32'(e), 32'({pkt2[i].last, pkt2[i].b}));
    end
    chk("pkt2_done_count", 32'(done_cnt), 32'd1);
    chk("pkt2_back_to_search", 32'(state_dbg), 32'd2);
    chk("pkt2_dp_select_held", 32'(dp_select), 32'd1);

    // 4. strobes stop after 3 header bits: timeout abort, then reset, re-latch
    send_aa(AA);
    send_bit(1'b1);
    send_bit(1'b0);
    value = 1'b1; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    for (k = 1; k < 200; k++) begin
      if (pkt_err) break;
      @(negedge clk);
    end
    chk("timeout_cycles", 32'(k - 1), 32'd64);
    chk("timeout_state", 32'(state_dbg), 32'd6);
    chk("timeout_dp_select_before", 32'(dp_select), 32'd1);
    dcnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (state_dbg == 3'd1 && dp_rst) dcnt++;
      if (state_dbg == 3'd2) break;
    end
    chk("abort_dprst_cycles", 32'(dcnt), 32'd16);
    chk("abort_search", 32'(state_dbg), 32'd2);
    chk("abort_relatch", 32'(dp_select), 32'd2);

    // 5. downstream stalled across two bytes: overflow abort
    byte_ready = 1'b0;
    send_aa(AA);
    send_data_byte(8'h5A);
    chk("ovf_first_valid", 32'(byte_valid), 32'd1);
    chk("ovf_first_data", 32'(byte_data), 32'h5A);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    value = 1'b0; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk("ovf_pkt_err", 32'(pkt_err), 32'd1);
    chk("ovf_valid_drop", 32'(byte_valid), 32'd0);
    chk("ovf_state", 32'(state_dbg), 32'd6);
    byte_ready = 1'b1;
    wait_state(3'd2, 60, "ovf_recover");
    rxq.delete();

    // 3. access-address tolerance table
    foreach (aa_tab[i]) begin
      resync();
      send_aa(aa_tab[i].aa);
      chk(aa_tab[i].name, 32'(state_dbg), 32'(aa_tab[i].exp_state));
      chk({aa_tab[i].name, "_novalid"}, 32'(byte_valid), 32'd0);
    end

    // 6. advertising-style packet on channel 37 (whitened when the feature is built)
    resync();
    cfg_select = 2'd1;
    resync();
    done_cnt = 0;
    rxq.delete();
    send_aa(AA);
    for (int i = 0; i < 7; i++) begin
      send_data_byte(pkt6[i].b);
      if (i == 0) cfg_select = 2'd2;
    end
    repeat (4) @(negedge clk);
    chk("pkt6_count", 32'(rxq.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      e = (rxq.size() > 0) ? rxq.pop_front() : 9'h1FF;
      chk($sformatf("pkt6_byte%0d", i), 32'(e), 32'({pkt6[i].last, pkt6[i].b}));
    end
    chk("pkt6_done_count", 32'(done_cnt), 32'd1);
    chk("pkt6_dp_select_held", 32'(dp_select), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
